// File: rtl/axis_pkt_fifo_buffer.sv
// Multi-channel AXI-Stream FIFO buffer: one independent {TLAST,TDATA} FIFO per channel
// with fill level, almost-full flag and optional store-and-forward packet release.
module axis_pkt_fifo_buffer #(
  parameter int unsigned CHANNEL_NUMBER  = 8,
  parameter int unsigned BUFFER_LENGTH   = 8,
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned PACKET_MODE     = 0,
  parameter int unsigned AFULL_THRESH    = 6
) (
  input  logic                                                ACLK,
  input  logic                                                ARESET,
  input  logic [CHANNEL_NUMBER*AXIS_DATA_WIDTH-1:0]           in_tdata_i,
  input  logic [CHANNEL_NUMBER-1:0]                           in_tlast_i,
  input  logic [CHANNEL_NUMBER-1:0]                           in_tvalid_i,
  output logic [CHANNEL_NUMBER-1:0]                           in_tready_o,
  output logic [CHANNEL_NUMBER*AXIS_DATA_WIDTH-1:0]           out_tdata_o,
  output logic [CHANNEL_NUMBER-1:0]                           out_tlast_o,
  output logic [CHANNEL_NUMBER-1:0]                           out_tvalid_o,
  input  logic [CHANNEL_NUMBER-1:0]                           out_tready_i,
  output logic [CHANNEL_NUMBER*($clog2(BUFFER_LENGTH)+1)-1:0] level_o,
  output logic [CHANNEL_NUMBER-1:0]                           almost_full_o
);

  localparam int unsigned LW = $clog2(BUFFER_LENGTH) + 1;
  localparam int unsigned AW = LW - 1;
  localparam int unsigned EW = AXIS_DATA_WIDTH + 1;

  for (genvar c = 0; c < CHANNEL_NUMBER; c++) begin : g_ch
    logic [EW-1:0] mem [BUFFER_LENGTH];
    logic [EW-1:0] rd_entry;
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nxt;
    logic [LW-1:0] pkt_cnt;
    logic          afull_q;
    logic          full;
    logic          empty;
    logic          pkt_ready;
    logic          valid;
    logic          wr_en;
    logic          rd_en;
    logic          wr_tlast;
    logic          rd_tlast;

    assign rd_entry = mem[rd_ptr[AW-1:0]];

    // The full term lets a packet longer than the FIFO drain cut-through instead of deadlocking.
    always_comb begin
      full      = (wr_ptr[LW-1] != rd_ptr[LW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      empty     = (wr_ptr == rd_ptr);
      pkt_ready = (PACKET_MODE == 0) || (pkt_cnt != '0) || full;
      valid     = !ARESET && !empty && pkt_ready;
      wr_en     = in_tvalid_i[c] && !full && !ARESET;
      rd_en     = valid && out_tready_i[c];
      wr_tlast  = wr_en && in_tlast_i[c];
      rd_tlast  = rd_en && rd_entry[EW-1];
      level_nxt = level_q;
      if (wr_en && !rd_en) begin
        level_nxt = level_q + LW'(1);
      end else if (rd_en && !wr_en) begin
        level_nxt = level_q - LW'(1);
      end
    end

    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
        pkt_cnt <= '0;
        afull_q <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + LW'(1);
        end
        if (rd_en) begin
          rd_ptr <= rd_ptr + LW'(1);
        end
        level_q <= level_nxt;
        afull_q <= (level_nxt >= LW'(AFULL_THRESH));
        if (wr_tlast && !rd_tlast) begin
          pkt_cnt <= pkt_cnt + LW'(1);
        end else if (rd_tlast && !wr_tlast) begin
          pkt_cnt <= pkt_cnt - LW'(1);
        end
      end
    end

    always_ff @(posedge ACLK) begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= {in_tlast_i[c], in_tdata_i[c*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]};
      end
    end

    assign in_tready_o[c]                                         = !full && !ARESET;
    assign out_tvalid_o[c]                                        = valid;
    assign out_tdata_o[c*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]      = rd_entry[AXIS_DATA_WIDTH-1:0];
    assign out_tlast_o[c]                                         = rd_entry[EW-1];
    assign level_o[c*LW +: LW]                                    = level_q;
    assign almost_full_o[c]                                       = afull_q;
  end

endmodule

// File: tb/tb_axis_pkt_fifo_buffer.sv
// Scoreboard bench for axis_pkt_fifo_buffer: a cut-through and a packet-mode instance
// share clock/reset; a negedge monitor models level/flags and checks every output beat.
module tb_axis_pkt_fifo_buffer;
  localparam int unsigned CH = 8;
  localparam int unsigned BL = 8;
  localparam int unsigned W  = 32;
  localparam int unsigned LW = 4;
  localparam int unsigned AF = 6;
  localparam int          NB = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CH*W-1:0]  in_tdata   [2];
  logic [CH-1:0]    in_tlast   [2];
  logic [CH-1:0]    in_tvalid  [2];
  logic [CH-1:0]    in_tready  [2];
  logic [CH*W-1:0]  out_tdata  [2];
  logic [CH-1:0]    out_tlast  [2];
  logic [CH-1:0]    out_tvalid [2];
  logic [CH-1:0]    out_tready [2];
  logic [CH*LW-1:0] level      [2];
  logic [CH-1:0]    afull      [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    axis_pkt_fifo_buffer #(
      .CHANNEL_NUMBER (CH),
      .BUFFER_LENGTH  (BL),
      .AXIS_DATA_WIDTH(W),
      .PACKET_MODE    (k),
      .AFULL_THRESH   (AF)
    ) dut (
      .ACLK         (clk),
      .ARESET       (rst),
      .in_tdata_i   (in_tdata[k]),
      .in_tlast_i   (in_tlast[k]),
      .in_tvalid_i  (in_tvalid[k]),
      .in_tready_o  (in_tready[k]),
      .out_tdata_o  (out_tdata[k]),
      .out_tlast_o  (out_tlast[k]),
      .out_tvalid_o (out_tvalid[k]),
      .out_tready_i (out_tready[k]),
      .level_o      (level[k]),
      .almost_full_o(afull[k])
    );
  end

  logic [W:0] sb [2*CH][$];
  int         tl_cnt [2*CH];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       rst_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: level/flag model from scoreboard occupancy, then pop on output handshake, push on input handshake.
  always @(negedge clk) begin
    int   s;
    int   sz;
    logic ev;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < int'(CH); c++) begin
        s  = k * CH + c;
        sz = sb[s].size();
        if (rst) begin
          check($sformatf("d%0d c%0d rst tready", k, c), 64'(in_tready[k][c]), 64'd0);
          check($sformatf("d%0d c%0d rst tvalid", k, c), 64'(out_tvalid[k][c]), 64'd0);
          if (rst_prev) begin
            check($sformatf("d%0d c%0d rst level", k, c), 64'(level[k][c*LW +: LW]), 64'd0);
            check($sformatf("d%0d c%0d rst afull", k, c), 64'(afull[k][c]), 64'd0);
          end
          sb[s].delete();
          tl_cnt[s] = 0;
        end else begin
          ev = (sz != 0) && (k == 0 || tl_cnt[s] != 0 || sz == int'(BL));
          check($sformatf("d%0d c%0d level", k, c), 64'(level[k][c*LW +: LW]), 64'(sz));
          check($sformatf("d%0d c%0d afull", k, c), 64'(afull[k][c]), 64'(sz >= int'(AF)));
          check($sformatf("d%0d c%0d tvalid", k, c), 64'(out_tvalid[k][c]), 64'(ev));
          check($sformatf("d%0d c%0d tready", k, c), 64'(in_tready[k][c]), 64'(sz != int'(BL)));
          if (out_tvalid[k][c] && out_tready[k][c]) begin
            if (sz == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL d%0d c%0d unexpected beat: got 0x%0h expected none", k, c,
                       {out_tlast[k][c], out_tdata[k][c*W +: W]});
            end else begin
              check($sformatf("d%0d c%0d beat", k, c),
                    64'({out_tlast[k][c], out_tdata[k][c*W +: W]}), 64'(sb[s][0]));
              if (sb[s][0][W]) tl_cnt[s]--;
              void'(sb[s].pop_front());
            end
          end
          if (in_tvalid[k][c] && in_tready[k][c]) begin
            sb[s].push_back({in_tlast[k][c], in_tdata[k][c*W +: W]});
            if (in_tlast[k][c]) tl_cnt[s]++;
          end
        end
      end
    end
    rst_prev = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input int c, input logic v, input logic [W-1:0] d, input logic l);
    in_tvalid[k][c]      = v;
    in_tdata[k][c*W +: W] = d;
    in_tlast[k][c]       = l;
  endtask

  task automatic send(input int k, input int c, input logic [W-1:0] d, input logic l);
    int n;
    n = 0;
    drive(k, c, 1'b1, d, l);
    @(negedge clk);
    while (!in_tready[k][c] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL d%0d c%0d send timeout: got no tready expected tready", k, c);
    end
    tick();
    drive(k, c, 1'b0, '0, 1'b0);
  endtask

  task automatic drain(input int k, input int c);
    int n;
    n = 0;
    out_tready[k][c] = 1'b1;
    while (level[k][c*LW +: LW] != '0 && n < 200) begin
      tick();
      n++;
    end
    check($sformatf("d%0d c%0d drained", k, c), 64'(level[k][c*LW +: LW]), 64'd0);
    out_tready[k][c] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] pk3 [3];
    int  sent [2*CH];
    bit  acc  [2*CH];
    int  cyc;
    bit  done;
    int  n;

    pk3[0] = 32'hA; pk3[1] = 32'hB; pk3[2] = 32'hC;
    for (int s = 0; s < 2 * int'(CH); s++) tl_cnt[s] = 0;

    // reset with random inputs
    for (int k = 0; k < 2; k++) begin
      in_tvalid[k] = '0; in_tlast[k] = '0; in_tdata[k] = '0; out_tready[k] = '0;
    end
    repeat (3) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        in_tvalid[k]  = CH'($urandom);
        in_tlast[k]   = CH'($urandom);
        out_tready[k] = CH'($urandom);
        for (int c = 0; c < int'(CH); c++) in_tdata[k][c*W +: W] = $urandom;
      end
    end
    for (int k = 0; k < 2; k++) begin
      in_tvalid[k] = '0; in_tlast[k] = '0; in_tdata[k] = '0; out_tready[k] = '0;
    end
    rst = 1'b0;
    tick();
    check("post-reset level d0", 64'(level[0]), 64'd0);
    check("post-reset tvalid d1", 64'(out_tvalid[1]), 64'd0);

    // cut-through fill to full, then drain
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 1'b1, W'(i), i == 8);
      tick();
      check("t2 level", 64'(level[0][LW-1:0]), 64'(i));
      check("t2 afull", 64'(afull[0][0]), 64'(i >= 6));
      check("t2 tready", 64'(in_tready[0][0]), 64'(i < 8));
    end
    drive(0, 0, 1'b0, '0, 1'b0);
    out_tready[0][0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t2 out tvalid", 64'(out_tvalid[0][0]), 64'd1);
      check("t2 out tdata", 64'(out_tdata[0][W-1:0]), 64'(i));
      tick();
      if (i == 1) check("t2 tready back", 64'(in_tready[0][0]), 64'd1);
    end
    check("t2 empty tvalid", 64'(out_tvalid[0][0]), 64'd0);
    out_tready[0][0] = 1'b0;

    // store-and-forward: held until TLAST stored
    out_tready[1][0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1'b1, pk3[i], i == 2);
      tick();
      drive(1, 0, 1'b0, '0, 1'b0);
      check("t3 held tvalid", 64'(out_tvalid[1][0]), 64'(i == 2));
      if (i < 2) begin
        tick();
        check("t3 held tvalid", 64'(out_tvalid[1][0]), 64'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      check("t3 tvalid", 64'(out_tvalid[1][0]), 64'd1);
      check("t3 tdata", 64'(out_tdata[1][W-1:0]), 64'(pk3[i]));
      check("t3 tlast", 64'(out_tlast[1][0]), 64'(i == 2));
      tick();
    end
    check("t3 done tvalid", 64'(out_tvalid[1][0]), 64'd0);
    out_tready[1][0] = 1'b0;

    // oversize packet escapes through the full term
    out_tready[1][1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(1, 1, W'(32'h100 + i), i == 9);
      if (i < 8) check("t4 start tvalid", 64'(out_tvalid[1][1]), 64'(i == 7));
    end
    drain(1, 1);

    // simultaneous read/write at level 4 on both instances
    for (int i = 0; i < 4; i++) begin
      drive(0, 2, 1'b1, W'(32'h200 + i), 1'b1);
      drive(1, 2, 1'b1, W'(32'h200 + i), 1'b1);
      tick();
    end
    out_tready[0][2] = 1'b1;
    out_tready[1][2] = 1'b1;
    for (int i = 4; i < 24; i++) begin
      drive(0, 2, 1'b1, W'(32'h200 + i), 1'b1);
      drive(1, 2, 1'b1, W'(32'h200 + i), 1'b1);
      tick();
      check("t5 level d0", 64'(level[0][2*LW +: LW]), 64'd4);
      check("t5 level d1", 64'(level[1][2*LW +: LW]), 64'd4);
    end
    drive(0, 2, 1'b0, '0, 1'b0);
    drive(1, 2, 1'b0, '0, 1'b0);
    drain(0, 2);
    drain(1, 2);

    // random traffic on all channels with a mid-run reset
    for (int s = 0; s < 2 * int'(CH); s++) begin
      sent[s] = 0;
      acc[s]  = 1'b0;
    end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < int'(CH); c++) begin
          acc[k*CH+c] = !rst && in_tvalid[k][c] && in_tready[k][c];
          if (acc[k*CH+c]) sent[k*CH+c]++;
        end
      tick();
      cyc++;
      rst = (cyc == 600);
      if (cyc == 601) begin
        check("t6 mid-reset level d0", 64'(level[0]), 64'd0);
        check("t6 mid-reset level d1", 64'(level[1]), 64'd0);
      end
      done = 1'b1;
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < int'(CH); c++) begin
          if (!in_tvalid[k][c] || acc[k*CH+c]) begin
            if (sent[k*CH+c] < NB && $urandom_range(1, 0) == 1)
              drive(k, c, 1'b1, $urandom,
                    (sent[k*CH+c] == NB - 1) || ($urandom_range(3, 0) == 0));
            else
              drive(k, c, 1'b0, '0, 1'b0);
          end
          out_tready[k][c] = 1'($urandom_range(1, 0));
          if (sent[k*CH+c] < NB || in_tvalid[k][c]) done = 1'b0;
        end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL t6 traffic timeout: got %0d cycles expected completion", cyc);
    end
    for (int k = 0; k < 2; k++) out_tready[k] = '1;
    n = 0;
    while ((level[0] != '0 || level[1] != '0) && n < 500) begin
      tick();
      n++;
    end
    tick();
    for (int s = 0; s < 2 * int'(CH); s++)
      check($sformatf("t6 sb%0d leftover", s), 64'(sb[s].size()), 64'd0);
    check("t6 final level d0", 64'(level[0]), 64'd0);
    check("t6 final level d1", 64'(level[1]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
